// File: rtl/test_monitor.sv
// test_monitor: watches a core for end-of-test (PC match, timeout, optional tohost store) and latches sticky results.
// Optional tohost mailbox enabled by defining TEST_MONITOR_TOHOST_EN.
module test_monitor #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] PASS_PC     = 32'h44,
    parameter int              TIMEOUT     = 5000,
    parameter int              CNT_W       = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc,
    input  logic             pc_valid,
    input  logic [XLEN-1:0]  gp,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             done_pulse,
    output logic [XLEN-2:0]  fail_code,
    output logic [CNT_W-1:0] cycles
);
    typedef enum logic [1:0] {RUN, PASS, FAIL, TOUT} state_t;
    state_t          state, nxt;
    logic [XLEN-2:0] code;
    logic            pc_hit, to_hit, th_hit;
    logic [XLEN-2:0] th_code;
`ifdef TEST_MONITOR_TOHOST_EN
    assign th_hit  = st_valid && st_addr == TOHOST_ADDR && st_data[0];
    assign th_code = st_data[XLEN-1:1];
`else
    assign th_hit  = 1'b0;
    assign th_code = '0;
    logic unused_st;
    assign unused_st = ^{st_valid, st_addr, st_data};
`endif
    assign pc_hit = pc_valid && pc == PASS_PC;
    assign to_hit = cycles == CNT_W'(TIMEOUT - 1);
    // Priority: tohost store, then PC match, then timeout.
    always_comb begin
        nxt  = th_hit ? (th_code == '0 ? PASS : FAIL) :
               pc_hit ? (gp == XLEN'(1) ? PASS : FAIL) :
               to_hit ? TOUT : RUN;
        code = th_hit ? th_code : gp[XLEN-1:1];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            done_pulse <= 1'b0;
            fail_code  <= '0;
            cycles     <= '0;
        end else begin
            done_pulse <= 1'b0;
            if (state == RUN) begin
                if (nxt != RUN) begin
                    state      <= nxt;
                    done       <= 1'b1;
                    pass       <= nxt == PASS;
                    fail       <= nxt != PASS;
                    timeout    <= nxt == TOUT;
                    done_pulse <= 1'b1;
                    fail_code  <= nxt == FAIL ? code : '0;
                end else begin
                    cycles <= &cycles ? cycles : cycles + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: randomized stimulus, reference model feeds a scoreboard queue checked by an independent monitor.
module tb_test_monitor;
    localparam int          XLEN = 32;
    localparam int          TOUT_N = 20;
    localparam logic [31:0] PPC = 32'h44;
    localparam logic [31:0] THA = 32'h1000;

    logic        clk = 0, rst = 1, pc_valid = 0, st_valid = 0;
    logic [31:0] pc = 0, gp = 0, st_addr = 0, st_data = 0;
    logic        done, pass, fail, timeout, done_pulse;
    logic [30:0] fail_code;
    logic [31:0] cycles;

    test_monitor #(.XLEN(XLEN), .PASS_PC(PPC), .TIMEOUT(TOUT_N), .CNT_W(32), .TOHOST_ADDR(THA)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .gp(gp),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .done_pulse(done_pulse), .fail_code(fail_code), .cycles(cycles));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        done, pass, fail, tout, pulse;
        logic [30:0] code;
        logic [31:0] cyc;
    } rec_t;
    rec_t q[$];
    int checks = 0, failures = 0;

    // outcome: 0 running, 1 passed, 2 failed, 3 timed out
    int          m_out = 0;
    int unsigned m_cyc = 0;
    logic [30:0] m_code = 0;
    logic        m_pulse = 0;

    task automatic model_step();
        bit th;
        m_pulse = 0;
        if (rst) begin
            m_out = 0; m_cyc = 0; m_code = 0;
        end else if (m_out == 0) begin
`ifdef TEST_MONITOR_TOHOST_EN
            th = st_valid && st_addr == THA && st_data[0];
`else
            th = 0;
`endif
            if (th) begin
                m_out = st_data[31:1] == 0 ? 1 : 2;
                m_code = m_out == 2 ? st_data[31:1] : 31'd0;
                m_pulse = 1;
            end else if (pc_valid && pc == PPC) begin
                m_out = gp == 1 ? 1 : 2;
                m_code = m_out == 2 ? gp[31:1] : 31'd0;
                m_pulse = 1;
            end else if (m_cyc == TOUT_N - 1) begin
                m_out = 3;
                m_pulse = 1;
            end else if (m_cyc != 32'hFFFF_FFFF) begin
                m_cyc++;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit v, input logic [31:0] p, input logic [31:0] g,
                       input bit sv, input logic [31:0] sa, input logic [31:0] sd);
        @(negedge clk);
        rst = r; pc_valid = v; pc = p; gp = g; st_valid = sv; st_addr = sa; st_data = sd;
        model_step();
        q.push_back('{m_out != 0, m_out == 1, m_out >= 2, m_out == 3, m_pulse, m_code, m_cyc});
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] p = $urandom;
        return p == PPC ? p + 4 : p;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, $urandom_range(0, 1), rnd_pc(), $urandom, $urandom_range(0, 1), $urandom, $urandom);
    endtask

    task automatic match(input logic [31:0] g);
        cyc(0, 1, PPC, g, 0, $urandom, $urandom);
    endtask

    initial begin : monitor
        rec_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{done, pass, fail, timeout, done_pulse, fail_code, cycles};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got d/p/f/t/pulse=%b%b%b%b%b code=%0d cyc=%0d exp %b%b%b%b%b code=%0d cyc=%0d",
                             $time, a.done, a.pass, a.fail, a.tout, a.pulse, a.code, a.cyc,
                             e.done, e.pass, e.fail, e.tout, e.pulse, e.code, e.cyc);
                end
            end
        end
    end

    initial begin
        // pass at cycle 10, later inputs ignored
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(10);
        match(1);
        idle(4);
        match(32'hB);
        // fail with code 5
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        match(32'hB);
        idle(3);
        // pc_valid gating, then timeout and a late match
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, PPC, 1, 0, 0, 0);
        idle(TOUT_N + 2);
        match(1);
        idle(2);
        // pc match on the final budget cycle wins over timeout
        cyc(1, 0, 0, 0, 0, 0, 0);
        while (m_cyc != TOUT_N - 1) idle(1);
        match(1);
        idle(2);
        // reset mid-run at cycle 7 and again after done
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(7);
        cyc(1, 1, PPC, 1, 0, 0, 0);
        idle(3);
        match(32'h6);
        idle(1);
        cyc(1, 1, PPC, 1, 0, 0, 0);
        idle(3);
`ifdef TEST_MONITOR_TOHOST_EN
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(0, 1, PPC, 1, 1, THA, 32'h7);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, THA, 32'h6);
        idle(2);
        cyc(0, 1, PPC, 5, 1, THA, 32'h1);
        idle(2);
`endif
        // random runs biased toward matches, gp==1 and occasional resets
        for (int r = 0; r < 40; r++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 30; i++) begin
                logic [31:0] sd = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 7)) : $urandom;
                cyc($urandom_range(0, 60) == 0, $urandom_range(0, 1),
                    $urandom_range(0, 12) == 0 ? PPC : rnd_pc(),
                    $urandom_range(0, 1) ? 32'd1 : $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 6) == 0 ? THA : $urandom, sd);
            end
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
